// File: rtl/debug_pkg.sv
// debug_pkg: shared FSM states and default frame geometry for the debug dump engine
package debug_pkg;
  localparam int NBITS_DEF = 32;
  localparam int N_REGS_DEF = 32;
  localparam int DM_WORDS_DEF = 32;
  localparam int RF_ADDR_W_DEF = 5;
  localparam int DM_ADDR_W_DEF = 32;
  localparam int RF_BASE = 2;
  localparam int DM_BASE = RF_BASE + N_REGS_DEF;
  localparam int WORDS_TOTAL = 2 + N_REGS_DEF + DM_WORDS_DEF;
  localparam int BYTES_PER_WORD = NBITS_DEF / 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETADDR,
    S_LATCH,
    S_TXBYTE,
    S_WAITTX,
    S_DONE,
    S_WAITLOW
  } state_t;
endpackage

// File: rtl/dbg_word_serializer.sv
// dbg_word_serializer: splits a loaded word into MSB-first bytes (in: load/word/start/ack; out: tx_start/tx_data/word_done)
module dbg_word_serializer #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NBITS-1:0] word,
  input  logic             start,
  input  logic             ack,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             word_done
);
  localparam int BPW = NBITS / 8;
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_start_q;
  logic last;
  assign last = byte_q == BW'(BPW - 1);
  assign word_done = ack && last;
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  always_comb begin
    shift_d = load ? word : (ack && !last) ? shift_q << 8 : shift_q;
    byte_d = load ? '0 : (ack && !last) ? byte_q + 1'b1 : byte_q;
    tx_data_d = start ? shift_q[NBITS-1 -: 8] : tx_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      byte_q <= '0;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      byte_q <= byte_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= start;
    end
  end
endmodule

// File: rtl/debug_tx_sequencer.sv
// debug_tx_sequencer: dumps PC, cycles, RF and DM as MSB-first bytes to uart_tx on send_flag (out: rf/dm_addr, tx_start/tx_data, send_done, busy)
module debug_tx_sequencer
  import debug_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int N_REGS = N_REGS_DEF,
  parameter int RF_ADDR_W = RF_ADDR_W_DEF,
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_ADDR_W = DM_ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send_flag,
  input  logic                 tx_done,
  input  logic [NBITS-1:0]     pc_val,
  input  logic [NBITS-1:0]     cycle_cnt,
  input  logic [NBITS-1:0]     rf_data,
  input  logic [NBITS-1:0]     dm_data,
  output logic [RF_ADDR_W-1:0] rf_addr,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 send_done,
  output logic                 busy
);
  localparam int WORDS = 2 + N_REGS + DM_WORDS;
  localparam int DM_LO = RF_BASE + N_REGS;
  localparam int WW = $clog2(WORDS);
  state_t state_q, state_d;
  logic [WW-1:0] word_idx_q, word_idx_d;
  logic [31:0] idx;
  logic [NBITS-1:0] word;
  logic in_rf, in_dm, load, start, ack, word_done;
  assign idx = 32'(word_idx_q);
  assign in_rf = idx >= RF_BASE && idx < DM_LO;
  assign in_dm = idx >= DM_LO;
  assign rf_addr = in_rf ? RF_ADDR_W'(idx - RF_BASE) : '0;
  assign dm_addr = in_dm ? DM_ADDR_W'(idx - DM_LO) : '0;
  assign word = idx == 0 ? pc_val : idx == 1 ? cycle_cnt : in_rf ? rf_data : dm_data;
  assign busy = state_q != S_IDLE;
  assign send_done = state_q == S_DONE;
  assign ack = tx_done && state_q == S_WAITTX;
  assign load = state_q == S_LATCH;
  assign start = state_q == S_TXBYTE;
  dbg_word_serializer #(.NBITS(NBITS)) u_ser (
    .clk       (clk),
    .rst       (reset),
    .load      (load),
    .word      (word),
    .start     (start),
    .ack       (ack),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .word_done (word_done)
  );
  always_comb begin
    state_d = state_q;
    word_idx_d = word_idx_q;
    case (state_q)
      S_IDLE: begin
        state_d = send_flag ? S_SETADDR : S_IDLE;
        word_idx_d = '0;
      end
      S_SETADDR: state_d = S_LATCH;
      S_LATCH: state_d = S_TXBYTE;
      S_TXBYTE: state_d = S_WAITTX;
      S_WAITTX: begin
        if (ack) state_d = !word_done ? S_TXBYTE : idx == WORDS - 1 ? S_DONE : S_SETADDR;
        if (word_done && idx != WORDS - 1) word_idx_d = word_idx_q + 1'b1;
      end
      S_DONE: state_d = S_WAITLOW;
      S_WAITLOW: state_d = send_flag ? S_WAITLOW : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_idx_q <= '0;
    end else begin
      state_q <= state_d;
      word_idx_q <= word_idx_d;
    end
  end
endmodule

// File: tb/tb_debug_tx_sequencer.sv
// tb_debug_tx_sequencer: randomized scoreboard bench for the debug dump engine
module tb_debug_tx_sequencer;
  logic clk = 1'b0;
  logic reset, send_flag, tx_done, uart_done, spur;
  logic [31:0] pc_val, cycle_cnt, rf_data, dm_data;
  logic [4:0] rf_addr;
  logic [31:0] dm_addr;
  logic tx_start, send_done, busy;
  logic [7:0] tx_data;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int dly = 10;
  bit dbl = 1'b0;
  int hold = 0;
  int cnt = 0;
  bit active = 1'b0;
  logic [7:0] cur;
  int mon_n = 0;

  always #5 clk = ~clk;
  assign tx_done = uart_done | spur;

  debug_tx_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .send_flag (send_flag),
    .tx_done   (tx_done),
    .pc_val    (pc_val),
    .cycle_cnt (cycle_cnt),
    .rf_data   (rf_data),
    .dm_data   (dm_data),
    .rf_addr   (rf_addr),
    .dm_addr   (dm_addr),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .send_done (send_done),
    .busy      (busy)
  );

  always @(posedge clk) begin
    rf_data <= 32'(rf_addr) * 32'd3;
    dm_data <= 32'hA500_0000 | dm_addr;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [31:0] pc, input logic [31:0] cy);
    logic [31:0] w;
    for (int i = 0; i < 66; i++) begin
      w = i == 0 ? pc : i == 1 ? cy : i < 34 ? 32'(i - 2) * 32'd3 : 32'hA500_0000 | 32'(i - 34);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
  endfunction

  always @(negedge clk) begin
    if (tx_start) begin
      n_cmp++;
      mon_n++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_byte #%0d: got %h expected none", mon_n, tx_data);
      end else begin
        cur = exp_q.pop_front();
        if (tx_data !== cur) begin
          n_err++;
          $display("FAIL frame_byte #%0d: got %h expected %h", mon_n, tx_data, cur);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      active = 1'b0;
      hold = 0;
    end else begin
      if (hold > 0) hold--;
      if (tx_start) begin
        cur = tx_data;
        cnt = dly;
        active = 1'b1;
      end else if (active) begin
        n_cmp++;
        if (tx_data !== cur) begin
          n_err++;
          $display("FAIL tx_data_stable: got %h expected %h", tx_data, cur);
        end
        cnt--;
        if (cnt == 0) begin
          active = 1'b0;
          hold = dbl ? 2 : 1;
        end
      end
    end
    uart_done = hold > 0;
  end

  task automatic run_dump(input logic [31:0] pc, input logic [31:0] cy, input bit hold_hi,
                          input bit drop, input bit chg, input int abort_at);
    int seen = 0;
    bit done = 1'b0;
    pc_val = pc;
    cycle_cnt = cy;
    mon_n = 0;
    push_frame(pc, cy);
    send_flag = 1'b1;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge clk);
      if (tx_start) begin
        seen++;
        if (seen == 1) chk("first_tx_latency", 32'(t + 1), 32'd4);
        if (chg && seen == 2) pc_val = $urandom;
        if (drop && seen == 3) send_flag = 1'b0;
      end
      if (send_done) done = 1'b1;
      if (abort_at > 0 && seen == abort_at) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_tx_start", 32'(tx_start), 32'd0);
        chk("abort_send_done", 32'(send_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        send_flag = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
    end
    chk("send_done_seen", 32'(done), 32'd1);
    chk("byte_count", 32'(seen), 32'd264);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    if (hold_hi) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("waitlow_quiet", {30'd0, tx_start, send_done}, 32'd0);
        chk("waitlow_busy", 32'(busy), 32'd1);
      end
    end
    send_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    send_flag = 1'b0;
    spur = 1'b0;
    uart_done = 1'b0;
    pc_val = '0;
    cycle_cnt = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_send_done", 32'(send_done), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_addr", {27'd0, rf_addr} | dm_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_tx", 32'(tx_start), 32'd0);
    dly = 10;
    dbl = 1'b1;
    run_dump(32'h0000_0040, 32'd7, 1'b0, 1'b0, 1'b0, 0);
    dly = 3;
    dbl = 1'b0;
    run_dump($urandom, $urandom, 1'b1, 1'b0, 1'b0, 0);
    dly = 10;
    run_dump($urandom, $urandom, 1'b0, 1'b0, 1'b0, 100);
    dly = 2;
    run_dump($urandom, $urandom, 1'b0, 1'b0, 1'b0, 0);
    run_dump($urandom, $urandom, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      dly = $urandom_range(1, 6);
      dbl = 1'($urandom_range(0, 1));
      run_dump($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
